// File: rtl/dct_block_loader_pkg.sv
// Shared constants, types and k-index helpers for the DCT block loader.
// Coefficient (r,c), with r and c in 1..8, lives at k=(r-1)*8+(c-1) in the flat block.
package dct_block_loader_pkg;

  localparam int unsigned N       = 10;
  localparam int unsigned CoeffW  = N + 1;
  localparam int unsigned BLK     = 64;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned BlkW    = BLK * CoeffW;
  localparam int unsigned CountW  = 16;

  typedef logic [N:0]        coeff_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [BlkW-1:0]   blk_t;
  typedef logic [CountW-1:0] count_t;

  localparam cnt_t CntLast = cnt_t'(BLK - 1);

  typedef enum logic [0:0] {
    StFill,
    StFull
  } state_e;

  // Flat index of coefficient (r,c); both indices are 1-based.
  function automatic int unsigned coeff_idx(input int unsigned r, input int unsigned c);
    return (r - 1) * 8 + (c - 1);
  endfunction

  // LSB position of slot k inside the flat block.
  function automatic int unsigned coeff_lsb(input int unsigned k);
    return k * CoeffW;
  endfunction

endpackage

// File: rtl/dct_block_loader_if.sv
// Stream-in / block-out signal bundle of the DCT block loader.
// master: upstream producer and downstream consumer side; slave: the loader.
interface dct_block_loader_if;
  import dct_block_loader_pkg::*;

  logic   flush;
  logic   in_valid;
  logic   in_ready;
  coeff_t in_data;
  logic   in_mode;
  logic   out_ready;
  logic   blk_valid;
  logic   blk_mode;
  blk_t   dct_blk;
  count_t blk_count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  blk_valid,
    input  blk_mode,
    input  dct_blk,
    input  blk_count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output blk_valid,
    output blk_mode,
    output dct_blk,
    output blk_count
  );

endinterface

// File: rtl/dct_block_loader.sv
// Collects 64 serial DCT coefficients into an 8x8 block and presents it in parallel with a
// one-cycle strobe; the fill buffer refills while the output register holds the last block.
module dct_block_loader
  import dct_block_loader_pkg::*;
(
  input logic              clk,
  input logic              srst,
  dct_block_loader_if.slave bus
);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   in_ready_q, in_ready_d;
  logic   mode_lat_q, mode_lat_d;
  logic   blk_valid_q, blk_valid_d;
  logic   blk_mode_q, blk_mode_d;
  count_t blk_count_q, blk_count_d;
  blk_t   dct_blk_q;
  blk_t   fill_flat;
  coeff_t fill_q [BLK];

  logic xfer;
  logic wr_en;
  logic load_out;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    mode_lat_d  = mode_lat_q;
    blk_valid_d = 1'b0;
    blk_mode_d  = blk_mode_q;
    blk_count_d = blk_count_q;
    wr_en       = 1'b0;
    load_out    = 1'b0;

    unique case (state_q)
      StFill: begin
        // flush wins over a same-cycle transfer, which is dropped
        if (bus.flush) begin
          cnt_d = '0;
        end else if (xfer) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_q == '0) begin
            mode_lat_d = bus.in_mode;
          end
          if (cnt_q == CntLast) begin
            state_d    = StFull;
            in_ready_d = 1'b0;
          end
        end
      end
      StFull: begin
        if (bus.out_ready) begin
          load_out    = 1'b1;
          blk_valid_d = 1'b1;
          blk_mode_d  = mode_lat_q;
          blk_count_d = blk_count_q + count_t'(1);
          state_d     = StFill;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d    = StFill;
        cnt_d      = '0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      mode_lat_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_mode_q  <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      mode_lat_q  <= mode_lat_d;
      blk_valid_q <= blk_valid_d;
      blk_mode_q  <= blk_mode_d;
      blk_count_q <= blk_count_d;
    end
  end

  // Slots are rewritten before reuse, so the fill buffer needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fill_q[cnt_q] <= bus.in_data;
    end
  end

  always_comb begin
    fill_flat = '0;
    for (int unsigned k = 0; k < BLK; k++) begin
      fill_flat[coeff_lsb(k) +: CoeffW] = fill_q[k];
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      dct_blk_q <= '0;
    end else if (load_out) begin
      dct_blk_q <= fill_flat;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_mode  = blk_mode_q;
  assign bus.dct_blk   = dct_blk_q;
  assign bus.blk_count = blk_count_q;

  a_strobe_single : assert property (@(posedge clk) disable iff (srst)
    blk_valid_q |=> !blk_valid_q);
  a_ready_state : assert property (@(posedge clk) disable iff (srst)
    in_ready_q == (state_q == StFill));
  a_full_cnt_zero : assert property (@(posedge clk) disable iff (srst)
    (state_q == StFull) |-> (cnt_q == '0));

endmodule
